// File: rtl/agc_pkg.sv
// agc_pkg: shared AGC state encoding and width constants.
package agc_pkg;
    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} agc_step_state_t;
    localparam int COUNTER2_W    = 8;
    localparam int AGC_GAIN_W    = 6;
    localparam int AGC_GAIN_INIT = 32;
endpackage

// File: rtl/agc_step_timer.sv
// agc_step_timer: STEP_DIV prescaler; pulses o_step on every STEP_DIV-th enabled cycle.
module agc_step_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic RESET,
    input  logic i_en,
    input  logic i_clr,
    output logic o_step
);
    localparam int DW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    logic [DW-1:0] r_div;
    assign o_step = i_en && !i_clr && r_div == DW'(STEP_DIV - 1);
    always_ff @(posedge clk) begin
        if (RESET || i_clr || !i_en || o_step) r_div <= '0;
        else r_div <= r_div + 1'b1;
    end
endmodule

// File: rtl/agc_gain_stepper.sv
// agc_gain_stepper: registered AGC gain code stepped in prescaled bursts,
// with sticky done on direction-reversal convergence or bound saturation.
module agc_gain_stepper
    import agc_pkg::*;
#(
    parameter int GAIN_W         = AGC_GAIN_W,
    parameter int GAIN_INIT      = AGC_GAIN_INIT,
    parameter int GAIN_MIN       = 0,
    parameter int GAIN_MAX       = 63,
    parameter int STEP_DIV       = 4,
    parameter int SETTLE_TOGGLES = 3,
    parameter int SAT_STEPS      = 16
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  counter2_mode,
    input  logic                  adjust,
    input  logic                  up_dn,
    output logic [GAIN_W-1:0]     gain,
    output logic                  gain_strobe,
    output logic [COUNTER2_W-1:0] counter2,
    output logic                  at_limit,
    output logic                  done
);
    localparam int TW = $clog2(SETTLE_TOGGLES + 1);
    localparam int SW = $clog2(SAT_STEPS + 1);

    agc_step_state_t       r_state, w_next;
    logic [GAIN_W-1:0]     r_gain;
    logic [COUNTER2_W-1:0] r_c2;
    logic [TW-1:0]         r_toggle;
    logic [SW-1:0]         r_sat;
    logic                  r_moved, r_strobe, r_done, r_have_prev, r_prev_dir;
    logic                  w_term, w_run, w_enter, w_step, w_clip, w_move, w_flip;

    assign w_term  = r_toggle == TW'(SETTLE_TOGGLES) || r_sat == SW'(SAT_STEPS);
    // Stepping stops as soon as a terminating count is visible, one cycle before done.
    assign w_run   = r_state != S_DONE && !w_term && adjust && counter2_mode;
    assign w_enter = r_state == S_IDLE && w_run;
    assign w_clip  = up_dn ? r_gain == GAIN_W'(GAIN_MAX) : r_gain == GAIN_W'(GAIN_MIN);
    assign w_move  = w_step && !w_clip;
    assign w_flip  = r_have_prev && up_dn != r_prev_dir;

    agc_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
        .clk   (clk),
        .RESET (RESET),
        .i_en  (w_run),
        .i_clr (!counter2_mode),
        .o_step(w_step)
    );

    always_ff @(posedge clk) begin
        if (RESET) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == S_DONE || w_term) ? S_DONE : (w_run ? S_BURST : S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_gain      <= GAIN_W'(GAIN_INIT);
            r_c2        <= '0;
            r_toggle    <= '0;
            r_sat       <= '0;
            r_moved     <= 1'b0;
            r_strobe    <= 1'b0;
            r_done      <= 1'b0;
            r_have_prev <= 1'b0;
            r_prev_dir  <= 1'b0;
        end else begin
            if (w_move) r_gain <= up_dn ? r_gain + 1'b1 : r_gain - 1'b1;
            r_moved  <= w_move;
            r_strobe <= r_moved && w_next != S_DONE;
            r_c2     <= !counter2_mode ? '0 : (w_step && r_c2 != '1) ? r_c2 + 1'b1 : r_c2;
            r_done   <= w_next == S_DONE;
            if (w_step) r_sat <= w_clip ? (r_sat == SW'(SAT_STEPS) ? r_sat : r_sat + 1'b1) : '0;
            if (w_enter) begin
                r_toggle    <= w_flip ? (r_toggle == TW'(SETTLE_TOGGLES) ? r_toggle : r_toggle + 1'b1) : '0;
                r_prev_dir  <= up_dn;
                r_have_prev <= 1'b1;
            end
        end
    end

    assign gain        = r_gain;
    assign gain_strobe = r_strobe;
    assign counter2    = r_c2;
    assign done        = r_done;
    assign at_limit    = r_gain == GAIN_W'(GAIN_MIN) || r_gain == GAIN_W'(GAIN_MAX);
endmodule

// File: tb/tb_agc_gain_stepper.sv
// tb_agc_gain_stepper: directed and random checks of two gain steppers against a behavioural model.
module tb_agc_gain_stepper;
    localparam int DIV = 4, TOG = 3, SAT = 16, GMIN = 0, GMAX = 63;

    typedef struct {
        int gain; bit strobe; bit moved; int c2; bit done; bit in_burst;
        int run; int toggles; int sats; bit have_prev; bit prev_dir;
    } mdl_t;

    logic clk = 1'b0, RESET = 1'b1, mode = 1'b0, adj = 1'b0, up = 1'b0;
    logic [5:0] gA, gB;
    logic [7:0] cA, cB;
    logic sA, sB, lA, lB, dA, dB;
    mdl_t ma, mb;
    bit started = 1'b0;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    agc_gain_stepper dut_a (.clk(clk), .RESET(RESET), .counter2_mode(mode), .adjust(adj), .up_dn(up),
        .gain(gA), .gain_strobe(sA), .counter2(cA), .at_limit(lA), .done(dA));
    agc_gain_stepper #(.GAIN_INIT(62)) dut_b (.clk(clk), .RESET(RESET), .counter2_mode(mode), .adjust(adj),
        .up_dn(up), .gain(gB), .gain_strobe(sB), .counter2(cB), .at_limit(lB), .done(dB));

    function automatic mdl_t mdl_reset(int init);
        mdl_t n;
        n.gain = init; n.strobe = 0; n.moved = 0; n.c2 = 0; n.done = 0; n.in_burst = 0;
        n.run = 0; n.toggles = 0; n.sats = 0; n.have_prev = 0; n.prev_dir = 0;
        return n;
    endfunction

    // One clock of the AGC stepper rules: qualifying adjust cycles are counted as a run,
    // every DIV-th cycle of a run is a step, entry direction compared with the last burst.
    function automatic mdl_t mdl_next(mdl_t s, int init, bit rst, bit a, bit u, bit m);
        mdl_t n = s;
        bit term, qual, step, clip;
        if (rst) return mdl_reset(init);
        term = s.toggles == TOG || s.sats == SAT;
        qual = !s.done && !term && a && m;
        n.run = qual ? s.run + 1 : 0;
        step = qual && (n.run % DIV == 0);
        clip = u ? s.gain == GMAX : s.gain == GMIN;
        if (qual && !s.in_burst) begin
            n.toggles = (s.have_prev && u != s.prev_dir) ? (s.toggles < TOG ? s.toggles + 1 : TOG) : 0;
            n.prev_dir = u;
            n.have_prev = 1;
        end
        if (step && clip) n.sats = s.sats < SAT ? s.sats + 1 : SAT;
        else if (step) begin
            n.sats = 0;
            n.gain = s.gain + (u ? 1 : -1);
        end
        n.c2 = !m ? 0 : (step && s.c2 < 255) ? s.c2 + 1 : s.c2;
        n.done = s.done || term;
        n.strobe = s.moved && !n.done;
        n.moved = step && !clip;
        n.in_burst = qual;
        return n;
    endfunction

    task automatic cmp(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        ma = mdl_reset(32);
        mb = mdl_reset(62);
    end

    always @(posedge clk) begin
        ma <= mdl_next(ma, 32, RESET, adj, up, mode);
        mb <= mdl_next(mb, 62, RESET, adj, up, mode);
        started <= 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            cmp("A_gain", gA, ma.gain);
            cmp("A_strobe", sA, ma.strobe);
            cmp("A_counter2", cA, ma.c2);
            cmp("A_at_limit", lA, ma.gain == GMIN || ma.gain == GMAX);
            cmp("A_done", dA, ma.done);
            cmp("B_gain", gB, mb.gain);
            cmp("B_strobe", sB, mb.strobe);
            cmp("B_counter2", cB, mb.c2);
            cmp("B_at_limit", lB, mb.gain == GMIN || mb.gain == GMAX);
            cmp("B_done", dB, mb.done);
        end
    end

    task automatic drive(bit a, bit u, bit m, int n);
        adj = a; up = u; mode = m;
        repeat (n) @(negedge clk);
    endtask

    task automatic rst1();
        RESET = 1'b1; adj = 1'b0; mode = 1'b0;
        @(negedge clk);
        RESET = 1'b0;
    endtask

    initial begin
        int strobes;
        repeat (2) @(negedge clk);
        cmp("rst_gainA", gA, 32);
        cmp("rst_gainB", gB, 62);
        cmp("rst_c2", cA, 0);
        cmp("rst_done", dA, 0);
        cmp("rst_strobe", sA, 0);
        cmp("rst_limA", lA, 0);
        RESET = 1'b0;

        strobes = 0;
        adj = 1; up = 1; mode = 1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            strobes += int'(sA);
            if (i == 3) cmp("up_pre_step", gA, 32);
            if (i == 4) cmp("up_step1", gA, 33);
            if (i == 5) cmp("up_strobe1", sA, 1);
            if (i == 8) cmp("up_step2", gA, 34);
            if (i == 12) begin
                cmp("up_step3", gA, 35);
                cmp("up_c2", cA, 3);
                adj = 0;
            end
        end
        cmp("up_strobes", strobes, 3);

        drive(1, 1, 1, 2);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        cmp("midrst_gain", gA, 32);
        cmp("midrst_c2", cA, 0);
        cmp("midrst_done", dA, 0);

        drive(1, 1, 1, 3);
        drive(0, 1, 1, 2);
        cmp("early_gain", gA, 32);
        cmp("early_c2", cA, 0);

        drive(1, 1, 1, 7);
        cmp("clr_pre_c2", cA, 1);
        drive(1, 1, 0, 1);
        cmp("clr_c2", cA, 0);
        cmp("clr_gain", gA, 33);
        drive(1, 1, 1, 3);
        cmp("clr_div_gain", gA, 33);
        drive(1, 1, 1, 1);
        cmp("clr_div_step", gA, 34);
        drive(0, 0, 0, 2);

        rst1();
        for (int b = 0; b < 3; b++) begin
            drive(1, b % 2 == 0, 1, 8);
            drive(0, b % 2 == 0, 0, 2);
            cmp("conv_gain", gA, b == 1 ? 32 : 34);
        end
        drive(1, 0, 1, 1);
        cmp("conv_done_pre", dA, 0);
        drive(1, 0, 1, 1);
        cmp("conv_done", dA, 1);
        drive(1, 0, 1, 8);
        cmp("conv_frozen", gA, 34);
        drive(1, 1, 0, 1);
        cmp("conv_done_sticky", dA, 1);

        rst1();
        adj = 1; up = 1; mode = 1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            cmp("sat_nonzero", gB == 0, 0);
            if (i == 4) begin
                cmp("sat_gain63", gB, 63);
                cmp("sat_limit", lB, 1);
            end
            if (i == 68) cmp("sat_done_pre", dB, 0);
            if (i == 69) cmp("sat_done", dB, 1);
        end
        cmp("sat_final", gB, 63);

        rst1();
        mode = 1;
        repeat (3000) begin
            if ($urandom_range(0, 5) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0) up = ~up;
            if ($urandom_range(0, 24) == 0) mode = ~mode;
            RESET = $urandom_range(0, 299) == 0;
            @(negedge clk);
        end
        RESET = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
